dut_cmd_arbiter: RTL

//   Shares the single dut slave command port (cmd/adr/data) among NREQ requesters.

---
 rtl/dut_cmd_arbiter_if.sv | 29 ++
 rtl/dut_cmd_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/dut_cmd_arbiter_if.sv
// Requester-side and slave-side handshake bundle for the command arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface dut_cmd_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 3
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*CMD_W-1:0]  req_cmd;
  logic [NREQ*ADR_W-1:0]  req_adr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   slv_valid;
  logic [CMD_W-1:0]       slv_cmd;
  logic [ADR_W-1:0]       slv_adr;
  logic [DATA_W-1:0]      slv_data;
  logic                   slv_ready;

  modport slave (
    input  req_valid, req_cmd, req_adr, req_data, slv_ready,
    output req_ready, slv_valid, slv_cmd, slv_adr, slv_data
  );

  modport master (
    output req_valid, req_cmd, req_adr, req_data, slv_ready,
    input  req_ready, slv_valid, slv_cmd, slv_adr, slv_data
  );
endinterface

// File: rtl/dut_cmd_arbiter.sv
// Round-robin arbiter with per-grant burst limit, feeding one registered
// output beat to the shared slave command port.
module dut_cmd_arbiter #(
  parameter int NREQ      = 4,
  parameter int CMD_W     = 2,
  parameter int ADR_W     = 4,
  parameter int DATA_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dut_cmd_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    grant_act
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, next_state;
  logic [IDW-1:0]       ptr, owner, pick;
  logic [3:0]           burst_cnt;
  logic [NREQ-1:0]      ready_vec;
  logic                 accept, last_beat, any_req;

  logic                 slv_valid_q;
  logic [CMD_W-1:0]     slv_cmd_q;
  logic [ADR_W-1:0]     slv_adr_q;
  logic [DATA_W-1:0]    slv_data_q;

  logic [NREQ-1:0][CMD_W-1:0]  cmd_a;
  logic [NREQ-1:0][ADR_W-1:0]  adr_a;
  logic [NREQ-1:0][DATA_W-1:0] data_a;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_a[i]  = bus.req_cmd[i*CMD_W +: CMD_W];
    assign adr_a[i]  = bus.req_adr[i*ADR_W +: ADR_W];
    assign data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign any_req   = |bus.req_valid;
  assign accept    = bus.req_valid[owner] && ready_vec[owner];
  assign last_beat = (burst_cnt == 4'(MAX_BURST - 1));

  // Scan downward so the last hit wins: that is the first valid from ptr upward.
  always_comb begin
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NREQ])
        pick = IDW'((int'(ptr) + k) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (any_req) next_state = GRANT;
      GRANT: if (!bus.req_valid[owner] || (accept && last_beat)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_vec = '0;
    grant_act = 1'b0;
    if (state == GRANT) begin
      grant_act        = 1'b1;
      ready_vec[owner] = !slv_valid_q || bus.slv_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      owner       <= '0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      slv_valid_q <= 1'b0;
      slv_cmd_q   <= '0;
      slv_adr_q   <= '0;
      slv_data_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= pick;
        grant_id  <= pick;
        burst_cnt <= '0;
      end
      // A new accept overwrites a draining beat, keeping 1 beat/cycle.
      if (state == GRANT && accept) begin
        slv_valid_q <= 1'b1;
        slv_cmd_q   <= cmd_a[owner];
        slv_adr_q   <= adr_a[owner];
        slv_data_q  <= data_a[owner];
        burst_cnt   <= burst_cnt + 4'd1;
      end else if (slv_valid_q && bus.slv_ready) begin
        slv_valid_q <= 1'b0;
        slv_cmd_q   <= '0;
        slv_adr_q   <= '0;
        slv_data_q  <= '0;
      end
      if (state == GRANT && next_state == IDLE)
        ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.slv_valid = slv_valid_q;
  assign bus.slv_cmd   = slv_cmd_q;
  assign bus.slv_adr   = slv_adr_q;
  assign bus.slv_data  = slv_data_q;
endmodule
